// File: rtl/counter_stim_gen_if.sv
// Control/status bundle between the stimulus sequencer and its consumers
// (the counter under test and the counter scoreboard).
interface counter_stim_gen_if;
  logic       start;
  logic       rco_in;
  logic       enable;
  logic [1:0] modo;
  logic [3:0] D;
  logic       busy;
  logic       done;
  logic [2:0] phase;
  logic [3:0] iter;
  logic [7:0] rco_count;

  modport master (
    input  start, rco_in,
    output enable, modo, D, busy, done, phase, iter, rco_count
  );

  modport slave (
    output start, rco_in,
    input  enable, modo, D, busy, done, phase, iter, rco_count
  );
endinterface

// File: rtl/counter_stim_gen.sv
// Stimulus sequencer for the 4-bit mode counter: iterates LOAD/UP/DN/DN3/DIS
// phases with a stepping load seed and counts returned rco pulses.
module counter_stim_gen #(
  parameter int unsigned N_UP      = 18,
  parameter int unsigned N_DN      = 18,
  parameter int unsigned N_D3      = 8,
  parameter int unsigned N_DIS     = 2,
  parameter int unsigned N_ITER    = 4,
  parameter logic [3:0]  SEED0     = 4'hA,
  parameter logic [3:0]  SEED_STEP = 4'h3
) (
  input logic               clk,
  input logic               reset_L,
  counter_stim_gen_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DN   = 3'd3,
    DN3  = 3'd4,
    DIS  = 3'd5,
    DONE = 3'd6
  } phase_t;

  localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

  phase_t     state, state_nxt, follow;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] iter_q, iter_nxt;
  logic [3:0] seed, seed_nxt;
  logic [7:0] rco_q;
  logic       rco_clr;
  logic       enable_q, enable_nxt;
  logic [1:0] modo_q, modo_nxt;
  logic [3:0] d_q, d_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;

  // First non-empty timed phase after p; IDLE stands for "end of iteration".
  function automatic phase_t timed_after(input phase_t p);
    if (p == LOAD && N_UP != 0) return UP;
    if ((p == LOAD || p == UP) && N_DN != 0) return DN;
    if ((p == LOAD || p == UP || p == DN) && N_D3 != 0) return DN3;
    if (p != DIS && N_DIS != 0) return DIS;
    return IDLE;
  endfunction

  function automatic logic [7:0] reload(input phase_t p);
    case (p)
      UP:      return 8'(N_UP - 1);
      DN:      return 8'(N_DN - 1);
      DN3:     return 8'(N_D3 - 1);
      DIS:     return 8'(N_DIS - 1);
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      cnt      <= '0;
      iter_q   <= '0;
      seed     <= SEED0;
      enable_q <= 1'b0;
      modo_q   <= 2'b00;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      iter_q   <= iter_nxt;
      seed     <= seed_nxt;
      enable_q <= enable_nxt;
      modo_q   <= modo_nxt;
      d_q      <= d_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    iter_nxt  = iter_q;
    seed_nxt  = seed;
    rco_clr   = 1'b0;
    follow    = timed_after(state);
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          iter_nxt  = '0;
          seed_nxt  = SEED0;
          rco_clr   = 1'b1;
        end
      end
      LOAD, UP, DN, DN3, DIS: begin
        if (state == LOAD || cnt == '0) begin
          if (follow != IDLE) begin
            state_nxt = follow;
            cnt_nxt   = reload(follow);
          end else if (iter_q == LAST_ITER) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
            iter_nxt  = iter_q + 4'd1;
            seed_nxt  = seed + SEED_STEP;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are decoded from the next phase so they register
  // together with it.
  always_comb begin
    enable_nxt = 1'b0;
    modo_nxt   = 2'b00;
    d_nxt      = '0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state_nxt)
      LOAD: begin
        enable_nxt = 1'b1;
        modo_nxt   = 2'b11;
        d_nxt      = seed_nxt;
        busy_nxt   = 1'b1;
      end
      UP: begin
        enable_nxt = 1'b1;
        d_nxt      = seed_nxt;
        busy_nxt   = 1'b1;
      end
      DN: begin
        enable_nxt = 1'b1;
        modo_nxt   = 2'b01;
        d_nxt      = seed_nxt;
        busy_nxt   = 1'b1;
      end
      DN3: begin
        enable_nxt = 1'b1;
        modo_nxt   = 2'b10;
        d_nxt      = seed_nxt;
        busy_nxt   = 1'b1;
      end
      DIS: begin
        d_nxt    = seed_nxt;
        busy_nxt = 1'b1;
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rco_q <= '0;
    end else if (rco_clr) begin
      rco_q <= '0;
    end else if (busy_q && bus.rco_in && rco_q != '1) begin
      rco_q <= rco_q + 8'd1;
    end
  end

  assign bus.enable    = enable_q;
  assign bus.modo      = modo_q;
  assign bus.D         = d_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.phase     = state;
  assign bus.iter      = iter_q;
  assign bus.rco_count = rco_q;

endmodule
